// File: rtl/sloc_pkg.sv
// Shared definitions for the sound-localisation path: default channel count
// and sample width (common to ADC_DataControl and the FIR), capture FSM
// state encoding, and width helpers for channel and address fields.
package sloc_pkg;

  // Default channel count and signed sample width of the localisation path
  localparam int SLOC_NCH = 4;
  localparam int SLOC_W   = 11;

  // Default capture geometry
  localparam int SLOC_DEPTH   = 64;
  localparam int SLOC_PRETRIG = 16;

  // Capture FSM state encoding, visible on the state output
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Channel index width; never narrower than one bit
  function automatic int sloc_cw(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  // Sample address width for a power-of-two depth
  function automatic int sloc_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sloc_cap_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// Each word holds one full sample set (all channels side by side); lane
// selection happens in the parent. Contents are not reset.
module sloc_cap_ram #(
  parameter int DW    = 44,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLOCK_50,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write one sample set per strobe
  always_ff @(posedge CLOCK_50) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; the word is held while no read is requested
  always_ff @(posedge CLOCK_50) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sloc_ch_capture.sv
// Multi-channel triggered capture buffer with pre/post-trigger window.
// All channels are written together into a circular memory on each sample
// strobe; a magnitude threshold on masked channels freezes a DEPTH-sample
// window (PRETRIG samples before the trigger) for readout.
// Optional build macro: SLOC_CAP_TIMESTAMP_EN adds a 32-bit sample-strobe
// counter whose value at the trigger sample is reported on trig_ts; without
// it trig_ts is tied to zero.
//
// Read handshake: rd_req has no ready. A request is accepted only while the
// FSM is in DONE; every accepted request produces exactly one rd_valid pulse
// with its rd_data two cycles later, one per cycle when back-to-back.
// Requests in any other state are dropped silently.
module sloc_ch_capture
  import sloc_pkg::*;
#(
  parameter  int NCH     = SLOC_NCH,
  parameter  int W       = SLOC_W,
  parameter  int DEPTH   = SLOC_DEPTH,
  parameter  int PRETRIG = SLOC_PRETRIG,
  localparam int CW      = sloc_cw(NCH),
  localparam int AW      = sloc_aw(DEPTH)
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               sample_en,
  input  logic [NCH*W-1:0]   ch_data,
  input  logic               arm,
  input  logic [W-1:0]       thresh,
  input  logic [NCH-1:0]     trig_mask,
  input  logic               rd_req,
  input  logic [CW-1:0]      rd_ch,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_valid,
  output logic [W-1:0]       rd_data,
  output logic [2:0]         state,
  output logic [CW-1:0]      trig_ch,
  output logic [31:0]        trig_ts
);

  // Last sample count in PRE (pre-window full) and in POST (post-window full)
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 1);

  logic [2:0]       state_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    start_ptr;
  logic [CW-1:0]    trig_ch_q;

  logic             capturing;
  logic             do_write;
  logic             enter_post;

  logic [W:0]       mag [NCH];
  logic [NCH-1:0]   hit;
  logic             hit_any;
  logic [CW-1:0]    hit_idx;

  logic             rd_accept;
  logic [AW-1:0]    rd_phys;
  logic [NCH*W-1:0] ram_q;
  logic             rd_v1;
  logic [CW-1:0]    rd_ch1;
  logic [W-1:0]     rd_lane;

  // Writes happen only while the window is being filled; arm takes priority
  // over a coincident strobe so that sample is discarded
  always_comb begin
    capturing  = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    do_write   = sample_en && !arm && capturing;
    enter_post = do_write && (state_q == ST_ARMED) && hit_any;
  end

  // Per-channel magnitude in W+1 bits so negative full scale does not overflow
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      mag[c] = ch_data[c*W+W-1] ? ((~{1'b1, ch_data[c*W +: W]}) + 1'b1)
                                : {1'b0, ch_data[c*W +: W]};
      hit[c] = trig_mask[c] && (mag[c] >= {1'b0, thresh});
    end
  end

  // Lowest-index firing channel wins
  always_comb begin
    hit_any = |hit;
    hit_idx = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        hit_idx = CW'(c);
      end
    end
  end

  // Capture FSM, write pointer, window counter and frozen window origin
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      start_ptr <= '0;
      trig_ch_q <= '0;
    end else if (arm) begin
      state_q   <= ST_PRE;
      wr_ptr    <= '0;
      cnt       <= '0;
      trig_ch_q <= '0;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + 1'b1;
      case (state_q)
        ST_PRE: begin
          if (cnt == PRE_LAST) begin
            state_q <= ST_ARMED;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          // The trigger sample itself is the first post-trigger sample
          if (hit_any) begin
            state_q   <= ST_POST;
            cnt       <= AW'(1);
            trig_ch_q <= hit_idx;
          end
        end
        ST_POST: begin
          if (cnt == POST_LAST) begin
            // Next write slot holds the oldest sample of the window
            state_q   <= ST_DONE;
            start_ptr <= wr_ptr + 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state   = state_q;
  assign trig_ch = trig_ch_q;

`ifdef SLOC_CAP_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_q;

  // Free-running sample-strobe counter since reset
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      ts_cnt <= '0;
    end else if (sample_en) begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  // Latch the trigger sample's timestamp (strobes before it) on entry to POST
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else if (enter_post) begin
      ts_q <= ts_cnt;
    end
  end

  assign trig_ts = ts_q;
`else
  assign trig_ts = '0;
`endif

  // Window index to physical slot, wrapping mod DEPTH
  always_comb begin
    rd_accept = rd_req && (state_q == ST_DONE);
    rd_phys   = start_ptr + rd_addr;
  end

  sloc_cap_ram #(
    .DW    (NCH*W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLOCK_50 (CLOCK_50),
    .we       (do_write),
    .waddr    (wr_ptr),
    .wdata    (ch_data),
    .re       (rd_accept),
    .raddr    (rd_phys),
    .rdata    (ram_q)
  );

  // First read stage tracks the request alongside the RAM read register
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      rd_v1  <= 1'b0;
      rd_ch1 <= '0;
    end else begin
      rd_v1  <= rd_accept;
      rd_ch1 <= rd_ch;
    end
  end

  // Select the requested channel lane from the full sample set
  always_comb begin
    rd_lane = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch1 == CW'(c)) begin
        rd_lane = ram_q[c*W +: W];
      end
    end
  end

  // Output register; unaffected by arm so in-flight reads still complete
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_v1;
      if (rd_v1) begin
        rd_data <= rd_lane;
      end
    end
  end

endmodule

// File: tb/tb_sloc_ch_capture.sv
// Bench for sloc_ch_capture: directed vectors, a history-based reference
// model checked every cycle, and hand-computed literal checks.
module tb_sloc_ch_capture;

  localparam int NCH = 4;
  localparam int W = 11;
  localparam int DEPTH = 64;
  localparam int PRETRIG = 16;
  localparam int CW = 2;
  localparam int AW = 6;

  // ---------------- clock / reset / DUT ----------------
  logic             CLOCK_50;
  logic             reset_n;
  logic             sample_en;
  logic [NCH*W-1:0] ch_data;
  logic             arm;
  logic [W-1:0]     thresh;
  logic [NCH-1:0]   trig_mask;
  logic             rd_req;
  logic [CW-1:0]    rd_ch;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [W-1:0]     rd_data;
  logic [2:0]       state;
  logic [CW-1:0]    trig_ch;
  logic [31:0]      trig_ts;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  sloc_ch_capture #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .PRETRIG(PRETRIG)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .ch_data   (ch_data),
    .arm       (arm),
    .thresh    (thresh),
    .trig_mask (trig_mask),
    .rd_req    (rd_req),
    .rd_ch     (rd_ch),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .state     (state),
    .trig_ch   (trig_ch),
    .trig_ts   (trig_ts)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;
  int vcount = 0;
  int n_strobes = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The window is modelled as the list of sample sets written since arm;
  // state follows from how many were written and where the trigger fell.
  logic [NCH*W-1:0] hist[$];
  bit               m_active;
  int               m_trig_idx;
  logic [CW-1:0]    m_trig_ch;
  logic [31:0]      m_ts_cnt;
  logic [31:0]      m_trig_ts;
  bit               m_p1_v, m_out_v;
  logic [W-1:0]     m_p1_d, m_out_d;

  function automatic int m_state();
    if (!m_active) return 0;
    if (hist.size() < PRETRIG) return 1;
    if (m_trig_idx < 0) return 2;
    if (hist.size() - m_trig_idx < DEPTH - PRETRIG) return 3;
    return 4;
  endfunction

  function automatic logic [W-1:0] mdl_lane(input int ch, input int addr);
    logic [NCH*W-1:0] s;
    s = hist[hist.size() - DEPTH + addr];
    return s[ch*W +: W];
  endfunction

  function automatic int lowest_fire(input logic [NCH*W-1:0] d);
    logic signed [W-1:0] sv;
    int x;
    for (int c = 0; c < NCH; c++) begin
      sv = d[c*W +: W];
      x = sv;
      if (x < 0) x = -x;
      if (trig_mask[c] && x >= int'(thresh)) return c;
    end
    return -1;
  endfunction

  always @(posedge CLOCK_50) begin
    int cur;
    int f;
    if (!reset_n) begin
      hist.delete();
      m_active = 0; m_trig_idx = -1; m_trig_ch = '0;
      m_ts_cnt = '0; m_trig_ts = '0;
      m_p1_v = 0; m_out_v = 0; m_p1_d = '0; m_out_d = '0;
    end else begin
      cur = m_state();
      m_out_v = m_p1_v;
      if (m_p1_v) m_out_d = m_p1_d;
      m_p1_v = rd_req && (cur == 4);
      if (m_p1_v) m_p1_d = mdl_lane(int'(rd_ch), int'(rd_addr));
      if (arm) begin
        m_active = 1; hist.delete(); m_trig_idx = -1; m_trig_ch = '0;
      end else if (sample_en && cur >= 1 && cur <= 3) begin
        if (cur == 2) begin
          f = lowest_fire(ch_data);
          if (f >= 0) begin
            m_trig_idx = hist.size();
            m_trig_ch = CW'(f);
            m_trig_ts = m_ts_cnt;
          end
        end
        hist.push_back(ch_data);
      end
      if (sample_en) m_ts_cnt = m_ts_cnt + 32'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      cmp("state", 32'(state), 32'(m_state()));
      cmp("trig_ch", 32'(trig_ch), 32'(m_trig_ch));
      cmp("rd_valid", 32'(rd_valid), 32'(m_out_v));
      if (m_out_v) cmp("rd_data", 32'(rd_data), 32'(m_out_d));
`ifdef SLOC_CAP_TIMESTAMP_EN
      cmp("trig_ts", trig_ts, m_trig_ts);
`else
      cmp("trig_ts", trig_ts, 32'd0);
`endif
      if (rd_valid === 1'b1) vcount++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  function automatic logic [NCH*W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [NCH*W-1:0] r;
    int t[4];
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = t[i][W-1:0];
    return r;
  endfunction

  task automatic send(input logic [NCH*W-1:0] d);
    sample_en = 1'b1; ch_data = d;
    tick();
    sample_en = 1'b0;
    n_strobes++;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_read(input int ch, input int addr, output logic [W-1:0] d);
    bit got;
    rd_req = 1'b1; rd_ch = CW'(ch); rd_addr = AW'(addr);
    tick();
    rd_req = 1'b0;
    got = 0; d = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (rd_valid === 1'b1) begin d = rd_data; got = 1; end
    end
    cmp("read_completes", 32'(got), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    int ts_exp;
    reset_n = 1'b0; sample_en = 1'b0; ch_data = '0; arm = 1'b0;
    thresh = '0; trig_mask = '0; rd_req = 1'b0; rd_ch = '0; rd_addr = '0;
    tick();
    chk_en = 1;
    tick(); tick();
    reset_n = 1'b1;
    n_strobes = 0;
    cmp("rst_state", 32'(state), 32'd0);
    cmp("rst_rd_valid", 32'(rd_valid), 32'd0);
    cmp("rst_trig_ch", 32'(trig_ch), 32'd0);
    cmp("rst_rd_data", 32'(rd_data), 32'd0);

    // Threshold capture on ch2, ramp on ch0
    thresh = 11'd300; trig_mask = 4'b0100;
    pulse_arm();
    cmp("t2_arm_state", 32'(state), 32'd1);
    ts_exp = 0;
    for (int n = 0; n < 88; n++) begin
      if (n == 40) ts_exp = n_strobes;
      send(pk(n, 0, (n == 40) ? 400 : 0, 0));
      if (n == 15) begin
        cmp("t2_armed_at_16", 32'(state), 32'd2);
        // Reads outside DONE are dropped
        rd_req = 1'b1; rd_addr = '0;
        for (int i = 0; i < 4; i++) begin
          tick();
          cmp("t5_no_read_armed", 32'(rd_valid), 32'd0);
        end
        rd_req = 1'b0;
      end
      if (n == 86) cmp("t2_post_before_87", 32'(state), 32'd3);
    end
    cmp("t2_done", 32'(state), 32'd4);
    cmp("t2_trig_ch", 32'(trig_ch), 32'd2);
`ifdef SLOC_CAP_TIMESTAMP_EN
    cmp("t6_trig_ts", trig_ts, 32'(ts_exp));
    cmp("t6_trig_ts_lit", trig_ts, 32'd40);
`else
    cmp("t6_trig_ts_off", trig_ts, 32'd0);
`endif
    cmp("mdl_ch2_a16", 32'(mdl_lane(2, 16)), 32'd400);
    cmp("mdl_ch0_a0", 32'(mdl_lane(0, 0)), 32'd24);
    cmp("mdl_ch0_a63", 32'(mdl_lane(0, 63)), 32'd87);
    do_read(2, 16, d); cmp("t2_ch2_a16", 32'(d), 32'd400);
    do_read(0, 0, d);  cmp("t2_ch0_a0", 32'(d), 32'd24);
    do_read(0, 63, d); cmp("t2_ch0_a63", 32'(d), 32'd87);
    do_read(2, 15, d); cmp("t2_ch2_a15", 32'(d), 32'd0);

    // Back-to-back burst over the whole window
    tick(); tick();
    vcount = 0;
    for (int i = 0; i < 64; i++) begin
      rd_req = 1'b1; rd_ch = '0; rd_addr = AW'(i);
      tick();
      cmp("t5_burst_v", 32'(rd_valid), 32'(i >= 1));
      if (i >= 1) cmp("t5_burst_d", 32'(rd_data), 32'(24 + i - 1));
    end
    rd_req = 1'b0;
    tick();
    cmp("t5_burst_last_v", 32'(rd_valid), 32'd1);
    cmp("t5_burst_last_d", 32'(rd_data), 32'd87);
    tick();
    cmp("t5_burst_end", 32'(rd_valid), 32'd0);
    tick();
    cmp("t5_burst_count", 32'(vcount), 32'd64);

    // Pre-window trigger ignored, then collision of arm and sample_en in POST
    thresh = 11'd300; trig_mask = 4'b0001;
    pulse_arm();
    for (int n = 0; n < 16; n++) send(pk(500, 0, 0, 0));
    cmp("t3_armed", 32'(state), 32'd2);
    send(pk(100, 0, 0, 0));
    cmp("t3_below", 32'(state), 32'd2);
    send(pk(-300, 0, 0, 0));
    cmp("t3_fire", 32'(state), 32'd3);
    cmp("t3_trig_ch", 32'(trig_ch), 32'd0);
    for (int n = 0; n < 5; n++) send(pk(n, 0, 0, 0));
    arm = 1'b1; sample_en = 1'b1; ch_data = pk(999, 0, 0, 0);
    tick();
    arm = 1'b0; sample_en = 1'b0; n_strobes++;
    cmp("t6_collide_state", 32'(state), 32'd1);
    for (int n = 0; n < 15; n++) send(pk(0, 0, 0, 0));
    cmp("t6_cnt_restart_15", 32'(state), 32'd1);
    send(pk(0, 0, 0, 0));
    cmp("t6_cnt_restart_16", 32'(state), 32'd2);

    // Negative full scale and threshold edges
    thresh = 11'd1024; trig_mask = 4'b0010;
    pulse_arm();
    for (int n = 0; n < 16; n++) send(pk(0, 0, 0, 0));
    send(pk(0, -1023, 0, 0));
    cmp("t4_1023_below_1024", 32'(state), 32'd2);
    send(pk(-1024, 1023, 0, 0));
    cmp("t4_masked_ch0", 32'(state), 32'd2);
    send(pk(0, -1024, 0, 0));
    cmp("t4_negfs_fire", 32'(state), 32'd3);
    cmp("t4_negfs_ch", 32'(trig_ch), 32'd1);

    thresh = 11'd1023; trig_mask = 4'b1010;
    pulse_arm();
    cmp("t4b_trig_ch_cleared", 32'(trig_ch), 32'd0);
    for (int n = 0; n < 16; n++) send(pk(0, 0, 0, 0));
    send(pk(0, -1023, 0, -1024));
    cmp("t4b_fire", 32'(state), 32'd3);
    cmp("t4b_lowest_ch", 32'(trig_ch), 32'd1);

    // Reset in POST aborts to IDLE
    for (int n = 0; n < 3; n++) send(pk(n, 0, 0, 0));
    reset_n = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    n_strobes = 0;
    cmp("t1_state", 32'(state), 32'd0);
    cmp("t1_rd_valid", 32'(rd_valid), 32'd0);
    cmp("t1_trig_ch", 32'(trig_ch), 32'd0);
    cmp("t1_trig_ts", trig_ts, 32'd0);
    pulse_arm();
    cmp("t1_arm_after", 32'(state), 32'd1);
    tick(); tick();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
